heq_frame_sequencer: RTL and testbench
======================================

Name: heq_frame_sequencer

Overview:
- Parametrised, multi-frame successor to the single-frame equalisation controller.
- Sequences the histogram/CDF input stage and the remap output stage over N frames using two ping-pong memory banks.
- Input of frame k+1 runs concurrently with output of frame k.
- Per bank, captures cdf_min from the input stage and derives the divisor handed to the output stage.

Parameters:
CDF_W, 20, width of cdf_min, cdf_min_out, divisor
NUM_PIXELS, 262144, pixels per frame (must be < 2**CDF_W)
FRAME_W, 8, width of frame counters / num_frames

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a run
num_frames  in  FRAME_W  frames in run, sampled when start accepted
input_start  out  1  single-cycle pulse launching input stage
input_done  in  1  single-cycle pulse, input stage finished frame
cdf_valid  in  1  single-cycle pulse qualifying cdf_min
cdf_min  in  CDF_W  minimum nonzero CDF of frame being ingested
input_base_offset  out  1  bank written by input stage
output_start  out  1  single-cycle pulse launching output stage
output_done  in  1  single-cycle pulse, output stage finished frame
cdf_min_out  out  CDF_W  cdf_min for frame being output
divisor  out  CDF_W  NUM_PIXELS - cdf_min_out (floored at 1)
output_base_offset  out  1  bank read by output stage
busy  out  1  high from accepted start until done
done  out  1  single-cycle pulse at end of run
frames_out  out  FRAME_W  frames fully output in current/last run
cdf_error  out  1  sticky: input_done seen with no cdf_valid in that frame

Behaviour:
- Reset (synchronous, while reset=1): all outputs 0; state IDLE; counters, bank registers, captured CDFs cleared. Reset mid-run aborts immediately; no start pulses emitted while reset=1 or in the cycle it deasserts.
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE:
  - start=1, num_frames>0: latch N, clear frames_out and cdf_error, busy=1, go to LAUNCH.
  - start=1, num_frames=0: done pulses next cycle, busy stays 0, remain IDLE.
  - start ignored when busy=1.
- Steps: run has N+1 steps, s=0..N.
  - Step s launches input of frame s if s<N, on bank s[0].
  - Step s launches output of frame s-1 if s>=1, on bank (s-1)[0].
- LAUNCH (one cycle):
  - Pulse input_start and/or output_start per step; set input_base_offset/output_base_offset in the same cycle.
  - On output_start cycle, load cdf_min_out and divisor from that bank's capture register; both held stable until next output_start.
  - Record which stages are outstanding; go to WAIT.
- WAIT:
  - Each outstanding stage cleared by its done pulse.
  - Done pulses from non-outstanding stages ignored.
  - input_done and output_done in the same cycle both count.
  - When none outstanding (cycle t): s<N goes to LAUNCH at t+1 (s incremented); s==N goes to FINISH.
- CDF capture:
  - cdf_valid while input outstanding latches cdf_min into the capture register of the current input bank; last value wins if repeated.
  - cdf_valid outside an input phase ignored.
  - input_done with no cdf_valid since that input_start: captured value=0, cdf_error set.
- Divisor: NUM_PIXELS - cdf_min computed in CDF_W bits, unsigned. If cdf_min >= NUM_PIXELS (uniform image), divisor=1.
- frames_out increments on each accepted output_done; it saturates at all-ones.
- FINISH: done=1 for one cycle, busy=0, return IDLE. Offsets and cdf_min_out hold their last values.
- Latencies:
  - Accepted start at cycle t gives input_start at t+1.
  - Last done of step at t gives next launch at t+1.
  - Final output_done at t gives done at t+1.

Test Plan:
- N=1, cdf_min=100 with input_done 10 cycles after input_start:
  - input_start bank0 at t+1.
  - After input_done, output_start bank0 with cdf_min_out=100, divisor=262044.
  - After output_done, done=1, frames_out=1.
- N=3, distinct cdf_min 5/6/7:
  - Banks alternate 0,1,0 on input.
  - Steps 1 and 2 issue input_start and output_start in the same cycle.
  - Output frames see cdf_min_out 5,6,7 with matching divisors.
  - done after 4 steps.
- N=2, step 1 with output_done 3 cycles after input_done, then reversed, then simultaneous: next launch exactly 1 cycle after the later done in every case.
- N=1, no cdf_valid before input_done: cdf_error=1, cdf_min_out=0, divisor=262144.
- cdf_min=262144: divisor=1.
- Robustness:
  - start during busy: ignored.
  - num_frames=0: done next cycle, no start pulses.
  - Reset asserted mid-WAIT: all outputs 0 next cycle.
  - Spurious output_done during step 0: ignored.

Source files
------------

// File: rtl/heq_frame_sequencer.sv
// Multi-frame histogram-equalisation sequencer: overlaps input of frame k+1 with
// output of frame k using two ping-pong banks, and forwards per-bank cdf_min/divisor.
module heq_frame_sequencer #(
    parameter int unsigned CDF_W      = 20,
    parameter int unsigned NUM_PIXELS = 262144,
    parameter int unsigned FRAME_W    = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] num_frames,
    output logic               input_start,
    input  logic               input_done,
    input  logic               cdf_valid,
    input  logic [CDF_W-1:0]   cdf_min,
    output logic               input_base_offset,
    output logic               output_start,
    input  logic               output_done,
    output logic [CDF_W-1:0]   cdf_min_out,
    output logic [CDF_W-1:0]   divisor,
    output logic               output_base_offset,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] frames_out,
    output logic               cdf_error
);

    localparam logic [CDF_W-1:0] NumPix = CDF_W'(NUM_PIXELS);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StFinish} state_e;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] n_q, n_d;
    logic [FRAME_W-1:0] step_q, step_d;
    logic               in_pend_q, in_pend_d;
    logic               out_pend_q, out_pend_d;
    logic               seen_q, seen_d;
    logic [CDF_W-1:0]   cap_q [2];
    logic [CDF_W-1:0]   cap_d [2];
    logic [CDF_W-1:0]   cdf_out_q, cdf_out_d;
    logic [CDF_W-1:0]   div_q, div_d;
    logic               in_bank_q, in_bank_d;
    logic               out_bank_q, out_bank_d;
    logic [FRAME_W-1:0] frames_q, frames_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic               in_launch, out_launch, out_sel;
    logic [CDF_W-1:0]   launch_cdf, launch_div;

    function automatic logic [CDF_W-1:0] calc_div(input logic [CDF_W-1:0] c);
        if (c >= NumPix) begin
            return CDF_W'(1);
        end
        return NumPix - c;
    endfunction

    // Output of frame s-1 reads bank (s-1)[0], i.e. the complement of s[0].
    assign out_sel    = ~step_q[0];
    assign in_launch  = (state_q == StLaunch) && (step_q < n_q);
    assign out_launch = (state_q == StLaunch) && (step_q != '0);
    assign launch_cdf = cap_q[out_sel];
    assign launch_div = calc_div(launch_cdf);

    assign input_start        = in_launch;
    assign output_start       = out_launch;
    assign input_base_offset  = in_launch ? step_q[0] : in_bank_q;
    assign output_base_offset = out_launch ? out_sel : out_bank_q;
    assign cdf_min_out        = out_launch ? launch_cdf : cdf_out_q;
    assign divisor            = out_launch ? launch_div : div_q;
    assign busy               = (state_q == StLaunch) || (state_q == StWait);
    assign done               = done_q;
    assign frames_out         = frames_q;
    assign cdf_error          = err_q;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        step_d     = step_q;
        in_pend_d  = in_pend_q;
        out_pend_d = out_pend_q;
        seen_d     = seen_q;
        cap_d[0]   = cap_q[0];
        cap_d[1]   = cap_q[1];
        cdf_out_d  = cdf_out_q;
        div_d      = div_q;
        in_bank_d  = in_bank_q;
        out_bank_d = out_bank_q;
        frames_d   = frames_q;
        err_d      = err_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_frames != '0) begin
                        n_d      = num_frames;
                        step_d   = '0;
                        frames_d = '0;
                        err_d    = 1'b0;
                        state_d  = StLaunch;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StLaunch: begin
                in_pend_d  = in_launch;
                out_pend_d = out_launch;
                if (in_launch) begin
                    in_bank_d = step_q[0];
                    seen_d    = 1'b0;
                end
                if (out_launch) begin
                    out_bank_d = out_sel;
                    cdf_out_d  = launch_cdf;
                    div_d      = launch_div;
                end
                state_d = StWait;
            end
            StWait: begin
                if (in_pend_q && cdf_valid) begin
                    cap_d[in_bank_q] = cdf_min;
                    seen_d           = 1'b1;
                end
                if (in_pend_q && input_done) begin
                    in_pend_d = 1'b0;
                    // A valid in the same cycle as done still counts as seen.
                    if (!seen_q && !cdf_valid) begin
                        cap_d[in_bank_q] = '0;
                        err_d            = 1'b1;
                    end
                end
                if (out_pend_q && output_done) begin
                    out_pend_d = 1'b0;
                    if (frames_q != '1) begin
                        frames_d = frames_q + FRAME_W'(1);
                    end
                end
                if (!in_pend_d && !out_pend_d) begin
                    if (step_q == n_q) begin
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end else begin
                        step_d  = step_q + FRAME_W'(1);
                        state_d = StLaunch;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            n_q        <= '0;
            step_q     <= '0;
            in_pend_q  <= 1'b0;
            out_pend_q <= 1'b0;
            seen_q     <= 1'b0;
            cap_q[0]   <= '0;
            cap_q[1]   <= '0;
            cdf_out_q  <= '0;
            div_q      <= '0;
            in_bank_q  <= 1'b0;
            out_bank_q <= 1'b0;
            frames_q   <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            step_q     <= step_d;
            in_pend_q  <= in_pend_d;
            out_pend_q <= out_pend_d;
            seen_q     <= seen_d;
            cap_q[0]   <= cap_d[0];
            cap_q[1]   <= cap_d[1];
            cdf_out_q  <= cdf_out_d;
            div_q      <= div_d;
            in_bank_q  <= in_bank_d;
            out_bank_q <= out_bank_d;
            frames_q   <= frames_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_heq_frame_sequencer.sv
// Bench for heq_frame_sequencer: directed and randomized runs, each frame's expected
// cdf/divisor/bank derived from the frame index and the value fed in for that frame.
module tb_heq_frame_sequencer;

    localparam int CDF_W = 20;
    localparam int NP    = 262144;
    localparam int FW    = 8;

    logic             clock;
    logic             reset;
    logic             start;
    logic [FW-1:0]    num_frames;
    logic             input_start;
    logic             input_done;
    logic             cdf_valid;
    logic [CDF_W-1:0] cdf_min;
    logic             input_base_offset;
    logic             output_start;
    logic             output_done;
    logic [CDF_W-1:0] cdf_min_out;
    logic [CDF_W-1:0] divisor;
    logic             output_base_offset;
    logic             busy;
    logic             done;
    logic [FW-1:0]    frames_out;
    logic             cdf_error;

    heq_frame_sequencer #(
        .CDF_W     (CDF_W),
        .NUM_PIXELS(NP),
        .FRAME_W   (FW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .num_frames        (num_frames),
        .input_start       (input_start),
        .input_done        (input_done),
        .cdf_valid         (cdf_valid),
        .cdf_min           (cdf_min),
        .input_base_offset (input_base_offset),
        .output_start      (output_start),
        .output_done       (output_done),
        .cdf_min_out       (cdf_min_out),
        .divisor           (divisor),
        .output_base_offset(output_base_offset),
        .busy              (busy),
        .done              (done),
        .frames_out        (frames_out),
        .cdf_error         (cdf_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-frame stimulus tables for the next run.
    int cdf_tab  [16];
    bit skip_tab [16];
    int di_tab   [16];
    int do_tab   [16];
    bit spur;
    bit busy_start;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d required %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int exp_div(input int c);
        return (c >= NP) ? 1 : NP - c;
    endfunction

    task automatic clear_inputs();
        start       = 1'b0;
        input_done  = 1'b0;
        output_done = 1'b0;
        cdf_valid   = 1'b0;
        cdf_min     = '0;
    endtask

    task automatic do_run(input int n);
        int exp_cdf [16];
        bit err;
        int di, dout, cv, d;
        err        = 1'b0;
        num_frames = FW'(n);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        num_frames = '0;
        for (int s = 0; s <= n; s++) begin
            check("input_start", 32'(input_start), 32'(s < n));
            check("output_start", 32'(output_start), 32'(s >= 1));
            check("busy", 32'(busy), 32'd1);
            check("frames_out_step", 32'(frames_out), (s >= 1) ? 32'(s - 1) : 32'd0);
            check("cdf_error_step", 32'(cdf_error), 32'(err));
            if (s < n) check("in_bank", 32'(input_base_offset), 32'(s % 2));
            if (s >= 1) begin
                check("out_bank", 32'(output_base_offset), 32'((s - 1) % 2));
                check("cdf_min_out", 32'(cdf_min_out), 32'(exp_cdf[s-1]));
                check("divisor", 32'(divisor), 32'(exp_div(exp_cdf[s-1])));
            end
            di   = (s < n) ? di_tab[s] : 0;
            dout = (s >= 1) ? do_tab[s] : 0;
            cv   = (di >= 2) ? int'($urandom_range(2, di)) : 1;
            d    = (di > dout) ? di : dout;
            tick();
            for (int c = 1; c <= d; c++) begin
                if (s < n && !skip_tab[s]) begin
                    if (c == 1 && cv != 1) begin
                        cdf_valid = 1'b1;
                        cdf_min   = CDF_W'($urandom);
                    end
                    if (c == cv) begin
                        cdf_valid = 1'b1;
                        cdf_min   = CDF_W'(cdf_tab[s]);
                    end
                end
                if (s < n && c == di + 1) begin
                    cdf_valid = 1'b1;
                    cdf_min   = CDF_W'($urandom);
                end
                if (c == di) input_done = 1'b1;
                if (c == dout) output_done = 1'b1;
                if (s == 0 && spur && c == 1) output_done = 1'b1;
                if (s == 0 && busy_start && c == 1) start = 1'b1;
                tick();
                clear_inputs();
                if (c < d) begin
                    check("mid_input_start", 32'(input_start), 32'd0);
                    check("mid_output_start", 32'(output_start), 32'd0);
                    check("mid_done", 32'(done), 32'd0);
                end
            end
            if (s < n) begin
                exp_cdf[s] = skip_tab[s] ? 0 : cdf_tab[s];
                if (skip_tab[s]) err = 1'b1;
            end
        end
        check("done", 32'(done), 32'd1);
        check("busy_finish", 32'(busy), 32'd0);
        check("frames_out", 32'(frames_out), 32'(n));
        check("cdf_error", 32'(cdf_error), 32'(err));
        check("cdf_hold", 32'(cdf_min_out), 32'(exp_cdf[n-1]));
        check("out_bank_hold", 32'(output_base_offset), 32'((n - 1) % 2));
        check("finish_starts", 32'({input_start, output_start}), 32'd0);
        tick();
        check("done_pulse", 32'(done), 32'd0);
    endtask

    task automatic set_plain(input int n);
        for (int i = 0; i < 16; i++) begin
            cdf_tab[i]  = 0;
            skip_tab[i] = 1'b0;
            di_tab[i]   = 3;
            do_tab[i]   = 3;
        end
        spur       = 1'b0;
        busy_start = 1'b0;
        if (n > 16) $fatal(1, "FAIL table_size: got %0d required <=16", n);
    endtask

    task automatic set_rand(input int n);
        set_plain(n);
        for (int i = 0; i < n + 1; i++) begin
            case ($urandom_range(0, 3))
                0:       cdf_tab[i] = int'($urandom_range(NP, (1 << CDF_W) - 1));
                default: cdf_tab[i] = int'($urandom_range(0, NP - 1));
            endcase
            skip_tab[i] = ($urandom_range(0, 7) == 0);
            di_tab[i]   = int'($urandom_range(1, 8));
            do_tab[i]   = int'($urandom_range(1, 8));
        end
        spur       = $urandom_range(0, 1) == 1;
        busy_start = $urandom_range(0, 1) == 1;
    endtask

    initial begin
        reset      = 1'b1;
        num_frames = '0;
        clear_inputs();
        tick();
        tick();
        check("rst_ctrl", 32'({input_start, input_base_offset, output_start,
                               output_base_offset, busy, done, cdf_error}), 32'd0);
        check("rst_cdf", 32'(cdf_min_out), 32'd0);
        check("rst_div", 32'(divisor), 32'd0);
        check("rst_frames", 32'(frames_out), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_starts", 32'({input_start, output_start}), 32'd0);

        // Single frame, cdf 100, long input phase.
        set_plain(1);
        cdf_tab[0] = 100;
        di_tab[0]  = 10;
        do_tab[1]  = 4;
        do_run(1);

        // Three frames, cdf 5/6/7, with a spurious output_done and a start while busy.
        set_plain(3);
        cdf_tab[0] = 5;
        cdf_tab[1] = 6;
        cdf_tab[2] = 7;
        spur       = 1'b1;
        busy_start = 1'b1;
        do_run(3);

        // Two frames: output later, input later, simultaneous.
        for (int v = 0; v < 3; v++) begin
            set_plain(2);
            cdf_tab[0] = 1000 + v;
            cdf_tab[1] = 2000 + v;
            di_tab[1]  = (v == 1) ? 5 : 2;
            do_tab[1]  = (v == 0) ? 5 : 2;
            do_run(2);
        end

        // Missing cdf_valid.
        set_plain(1);
        skip_tab[0] = 1'b1;
        do_run(1);

        // Uniform image.
        set_plain(1);
        cdf_tab[0] = NP;
        do_run(1);

        // Zero-frame run.
        num_frames = '0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_starts", 32'({input_start, output_start}), 32'd0);
        tick();
        check("zero_done_pulse", 32'(done), 32'd0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 6));
            set_rand(n);
            do_run(n);
        end

        // Reset mid-WAIT during step 1 of a three-frame run.
        num_frames = 8'd3;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        tick();
        tick();
        input_done = 1'b1;
        cdf_valid  = 1'b1;
        cdf_min    = 20'd77;
        tick();
        clear_inputs();
        check("pre_rst_in_bank", 32'(input_base_offset), 32'd1);
        check("pre_rst_cdf", 32'(cdf_min_out), 32'd77);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_ctrl", 32'({input_start, input_base_offset, output_start,
                                   output_base_offset, busy, done, cdf_error}), 32'd0);
        check("mid_rst_cdf", 32'(cdf_min_out), 32'd0);
        check("mid_rst_div", 32'(divisor), 32'd0);
        check("mid_rst_frames", 32'(frames_out), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_release_starts", 32'({input_start, output_start, busy}), 32'd0);

        set_plain(1);
        cdf_tab[0] = 4242;
        do_run(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
